judgement_unit: RTL and testbench
=================================

# judgement_unit

Per-lane hit judgement generator for the two note lanes (up/down). It times each player key press against an open note window and emits one 2-bit judgement code per lane per cycle. Those codes feed `ScoreConversion` on `judgement_up`/`judgement_down`. It also keeps running 16-bit perfect/good/miss tallies for the result screen.

## Interface
- `WIN_LEN`, 16: judgement window length in cycles, 2..255.
- `PERF_LO`, 6: first window offset judged PERFECT.
- `PERF_HI`, 9: last window offset judged PERFECT. Requires `PERF_LO <= PERF_HI < WIN_LEN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `pause` input 1: freezes all lane state and tallies while high.
- `note_open_up` input 1: one-cycle pulse; a note enters the up-lane window.
- `note_open_down` input 1: one-cycle pulse; a note enters the down-lane window.
- `key_up` input 1: one-cycle press pulse for the up lane, already edge-detected upstream.
- `key_down` input 1: one-cycle press pulse for the down lane.
- `judgement_up` output 2: registered up-lane judgement. Codes: 00 PERFECT, 01 GOOD, 10 MISS, 11 NO_NOTE.
- `judgement_down` output 2: registered down-lane judgement, same encoding.
- `perfect_cnt` output 16: total PERFECT judgements.
- `good_cnt` output 16: total GOOD judgements.
- `miss_cnt` output 16: total MISS judgements.

## Operation
- Two identical lane FSMs, each with states IDLE and ARMED, plus an 8-bit offset counter `c`.
- **Reset** (`rst_n` low at an edge): both lanes go to IDLE with `c = 0`. Judgements become 11. All tallies become 0.
- **Default output:** every cycle, a lane's judgement register loads 11 unless an event below applies.
- **IDLE:**
  - `note_open` moves the lane to ARMED with `c = 0`.
  - A key press in IDLE is ignored; no judgement is produced.
  - If `note_open` and key arrive in the same IDLE cycle, the window opens and the key is ignored.
- **ARMED, key pressed:**
  - Judgement loads 00 if `PERF_LO <= c <= PERF_HI`, otherwise 01.
  - Lane returns to IDLE.
- **ARMED, no key, `c == WIN_LEN-1`:** judgement loads 10 and the lane returns to IDLE.
- **ARMED, no key, otherwise:** `c` increments.
- **ARMED, `note_open` arrives:**
  - With a key in the same cycle: the key judges the current note (00/01), then a new window starts with `c = 0`, lane stays ARMED.
  - Without a key: the current note is judged 10, then a new window starts with `c = 0`.
- **Pause:** while `pause` is high, lane state, `c` and tallies hold. Judgements load 11. Note and key pulses are dropped.
- **Tallies:** each cycle, a tally adds the number of lanes (0, 1 or 2) whose newly loaded judgement matches its class. Tallies saturate at 65535 and never wrap.
- The two lanes are fully independent; simultaneous events on both lanes are legal.

## Timing
- A judgement appears on the output exactly 1 cycle after the edge that sampled the key, the timeout or the `note_open`. It is valid for one cycle, then returns to 11.
- Counter offset: the `note_open` cycle sets `c = 0`. A key pulse k cycles after the `note_open` pulse is judged at `c = k-1`, for k >= 1.
- Timeout: with no key, MISS is output `WIN_LEN+1` cycles after the `note_open` pulse.
- Tallies update on the same edge that loads the judgement register, so they stay consistent with the outputs.
- Reset has priority over `pause` and over all pulses. A reset mid-window discards the note with no MISS output.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with pulses active → judgements 11, all counts 0, both lanes IDLE.
- **Perfect/good/miss boundaries** (defaults):
  - Up-lane `note_open`, then key 7 cycles later (`c = 6`) → `judgement_up` = 00 for one cycle, `perfect_cnt` = 1.
  - Repeat with key 11 cycles later (`c = 10`) → 01.
  - Repeat with no key → 10 exactly 17 cycles after `note_open`, `miss_cnt` = 1.
- **Back-to-back notes:**
  - Second `note_open_up` 5 cycles after the first, no key → MISS the next cycle, and the new window times from `c = 0`.
  - Same, but with a key in the same cycle as the second `note_open` → GOOD for the first note, and the new window opens.
- **Stray and simultaneous inputs:**
  - Key in IDLE → output stays 11, counts unchanged.
  - Both lanes judged PERFECT in the same cycle → `perfect_cnt` increments by 2.
- **Pause:** assert `pause` for 20 cycles at `c = 3` → no MISS output. After release, the window resumes from `c = 3`.
- **Saturation:** preload tallies near limit, e.g. 65534 perfect plus a dual PERFECT → `perfect_cnt` = 65535, and further PERFECTs hold it at 65535.

Source files
------------

// File: rtl/judgement_unit.sv
// Two-lane note hit judgement: times key presses against a per-lane note window,
// emits registered PERFECT/GOOD/MISS/NO_NOTE codes and saturating result tallies.
module judgement_unit #(
    parameter int WIN_LEN = 16,
    parameter int PERF_LO = 6,
    parameter int PERF_HI = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause,
    input  logic        note_open_up,
    input  logic        note_open_down,
    input  logic        key_up,
    input  logic        key_down,
    output logic [1:0]  judgement_up,
    output logic [1:0]  judgement_down,
    output logic [15:0] perfect_cnt,
    output logic [15:0] good_cnt,
    output logic [15:0] miss_cnt
);

    localparam logic [1:0] PERFECT = 2'b00;
    localparam logic [1:0] GOOD    = 2'b01;
    localparam logic [1:0] MISS    = 2'b10;
    localparam logic [1:0] NO_NOTE = 2'b11;

    localparam logic [7:0] PERF_LO_C = 8'(PERF_LO);
    localparam logic [7:0] PERF_HI_C = 8'(PERF_HI);
    localparam logic [7:0] LAST_C    = 8'(WIN_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } lane_state_t;

    // Lane 0 is the up lane, lane 1 the down lane.
    logic [1:0]       note_open;
    logic [1:0]       key;
    logic [1:0][1:0]  judge_next_all;
    logic [1:0][1:0]  judge_reg_all;
    logic [2:0][15:0] tally_reg;

    assign note_open = {note_open_down, note_open_up};
    assign key       = {key_down, key_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            lane_state_t state_reg, state_next;
            logic [7:0]  c_reg, c_next;
            logic [1:0]  judge_reg, judge_next;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    c_reg     <= '0;
                    judge_reg <= NO_NOTE;
                end else begin
                    state_reg <= state_next;
                    c_reg     <= c_next;
                    judge_reg <= judge_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                c_next     = c_reg;
                judge_next = NO_NOTE;
                if (!pause) begin
                    case (state_reg)
                        IDLE: begin
                            if (note_open[gi]) begin
                                state_next = ARMED;
                                c_next     = '0;
                            end
                        end
                        ARMED: begin
                            // A key always judges the current note, even on the last offset
                            // or when a new note opens in the same cycle.
                            if (key[gi]) begin
                                judge_next = (c_reg >= PERF_LO_C && c_reg <= PERF_HI_C) ? PERFECT : GOOD;
                            end else if (note_open[gi] || c_reg == LAST_C) begin
                                judge_next = MISS;
                            end
                            if (note_open[gi]) begin
                                c_next = '0;
                            end else if (key[gi] || c_reg == LAST_C) begin
                                state_next = IDLE;
                                c_next     = '0;
                            end else begin
                                c_next = c_reg + 8'd1;
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            c_next     = '0;
                        end
                    endcase
                end
            end

            assign judge_next_all[gi] = judge_next;
            assign judge_reg_all[gi]  = judge_reg;
        end
    endgenerate

    // Tally index equals the judgement code it counts: 0 perfect, 1 good, 2 miss.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tally
            logic [1:0]  hits;
            logic [16:0] sum;

            assign hits = {1'b0, judge_next_all[0] == 2'(gi)} + {1'b0, judge_next_all[1] == 2'(gi)};
            assign sum  = {1'b0, tally_reg[gi]} + {15'd0, hits};

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tally_reg[gi] <= '0;
                end else begin
                    tally_reg[gi] <= sum[16] ? 16'hFFFF : sum[15:0];
                end
            end
        end
    endgenerate

    assign judgement_up   = judge_reg_all[0];
    assign judgement_down = judge_reg_all[1];
    assign perfect_cnt    = tally_reg[0];
    assign good_cnt       = tally_reg[1];
    assign miss_cnt       = tally_reg[2];

endmodule

// File: tb/tb_judgement_unit.sv
// Scoreboard bench for judgement_unit: a timestamp-based lane model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_judgement_unit;

    localparam int WIN_LEN = 16;
    localparam int PERF_LO = 6;
    localparam int PERF_HI = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause = 1'b0;
    logic        note_open_up = 1'b0;
    logic        note_open_down = 1'b0;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic [1:0]  judgement_up;
    logic [1:0]  judgement_down;
    logic [15:0] perfect_cnt;
    logic [15:0] good_cnt;
    logic [15:0] miss_cnt;

    judgement_unit #(.WIN_LEN(WIN_LEN), .PERF_LO(PERF_LO), .PERF_HI(PERF_HI)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pause         (pause),
        .note_open_up  (note_open_up),
        .note_open_down(note_open_down),
        .key_up        (key_up),
        .key_down      (key_down),
        .judgement_up  (judgement_up),
        .judgement_down(judgement_down),
        .perfect_cnt   (perfect_cnt),
        .good_cnt      (good_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ju;
        logic [1:0]  jd;
        logic [15:0] p;
        logic [15:0] g;
        logic [15:0] m;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     verbose = 1'b1;

    // Reference model: time advances only on unpaused cycles; each armed lane remembers
    // the time its note opened, and the key offset is the elapsed time minus one.
    longint t = 0;
    bit     armed[2] = '{1'b0, 1'b0};
    longint t0[2] = '{0, 0};
    int     cnt[3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input bit r, input bit p, input bit ou, input bit od, input bit ku, input bit kd);
        bit         op[2];
        bit         ky[2];
        logic [1:0] j[2];
        exp_t       e;
        rst_n = r;
        pause = p;
        note_open_up = ou;
        note_open_down = od;
        key_up = ku;
        key_down = kd;
        op = '{ou, od};
        ky = '{ku, kd};
        j = '{2'd3, 2'd3};
        @(posedge clk);
        if (!r) begin
            armed = '{1'b0, 1'b0};
            cnt = '{0, 0, 0};
        end else if (!p) begin
            t++;
            for (int l = 0; l < 2; l++) begin
                if (armed[l]) begin
                    longint off;
                    off = t - t0[l] - 1;
                    if (ky[l]) j[l] = (off >= PERF_LO && off <= PERF_HI) ? 2'd0 : 2'd1;
                    else if (op[l] || (t - t0[l]) == WIN_LEN) j[l] = 2'd2;
                    if (j[l] != 2'd3) armed[l] = 1'b0;
                end
                if (op[l]) begin
                    armed[l] = 1'b1;
                    t0[l] = t;
                end
                if (j[l] != 2'd3 && cnt[j[l]] < 65535) cnt[j[l]]++;
            end
        end
        e.ju = j[0];
        e.jd = j[1];
        e.p = 16'(cnt[0]);
        e.g = 16'(cnt[1]);
        e.m = 16'(cnt[2]);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("judgement_up", {14'd0, judgement_up}, {14'd0, e.ju});
            chk("judgement_down", {14'd0, judgement_down}, {14'd0, e.jd});
            chk("perfect_cnt", perfect_cnt, e.p);
            chk("good_cnt", good_cnt, e.g);
            chk("miss_cnt", miss_cnt, e.m);
            if (verbose && (e.ju != 2'd3 || e.jd != 2'd3))
                $display("t=%0t up=%b down=%b perfect=%0d good=%0d miss=%0d",
                         $time, judgement_up, judgement_down, perfect_cnt, good_cnt, miss_cnt);
        end
    end

    initial begin
        // Reset held with every pulse active
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 1, 1, 1, 1);
        idle(3);

        // PERFECT at c=6, GOOD at c=10, MISS on timeout
        step(1, 0, 1, 0, 0, 0); idle(6); step(1, 0, 0, 0, 1, 0); idle(3);
        step(1, 0, 1, 0, 0, 0); idle(10); step(1, 0, 0, 0, 1, 0); idle(3);
        step(1, 0, 1, 0, 0, 0); idle(20);

        // Back-to-back notes: without and with a key on the second open
        step(1, 0, 1, 0, 0, 0); idle(4); step(1, 0, 1, 0, 0, 0); idle(20);
        step(1, 0, 1, 0, 0, 0); idle(4); step(1, 0, 1, 0, 1, 0); idle(20);

        // Stray keys in IDLE, then dual PERFECT
        step(1, 0, 0, 0, 1, 1); idle(2);
        step(1, 0, 1, 1, 0, 0); idle(6); step(1, 0, 0, 0, 1, 1); idle(3);

        // Pause at c=3 with pulses dropped, then resume to timeout
        step(1, 0, 1, 0, 0, 0); idle(3);
        for (int i = 0; i < 20; i++) step(1, 1, i == 5, i == 7, i == 9, i == 11);
        idle(20);

        // Randomized traffic including occasional pause and reset
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        idle(20);

        // Saturation: two GOODs per cycle until good_cnt pins at 65535
        verbose = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 33000; i++) step(1, 0, 1, 1, 1, 1);
        verbose = 1'b1;
        idle(20);

        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
